// File: rtl/scaler_pkg.sv
// Shared (4.12) fixed-point definitions used by the horizontal and vertical scalers.
package scaler_pkg;

    localparam int FRAC_W = 12;
    localparam int INT_W = 12;
    localparam int ACC_W = INT_W + FRAC_W;
    localparam int PIXEL_STEP = 4096;

    typedef logic [ACC_W-1:0] acc_t;
    typedef logic [15:0] step_t;

    // Only downscaling or 1:1 is supported, so never step below unity.
    function automatic step_t clamp_step(step_t s, step_t unity);
        return (s < unity) ? unity : s;
    endfunction

endpackage

// File: rtl/scaler_v_if.sv
// Video stream bundle: pixel data plus enable and sync strobes.
interface scaler_v_if #(
    parameter int DW = 8
);

    logic [DW-1:0] pix;
    logic de;
    logic hs;
    logic vs;

    modport master (output pix, de, hs, vs);
    modport slave (input pix, de, hs, vs);

endinterface

// File: rtl/scaler_v_linebuf.sv
// Simple dual-port line store with a registered, read-before-write read port.
module scaler_v_linebuf #(
    parameter int DW = 8,
    parameter int DEPTH = 4096,
    parameter int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/scaler_v.sv
// Vertical downscaler: blends the stored previous line with the current one.
// Define SCALER_V_ROUND_EN to round the blend instead of truncating it.
module scaler_v #(
    parameter int DATA_WIDTH = 8,
    parameter int COE_WIDTH = 10,
    parameter int PIXEL_STEP = scaler_pkg::PIXEL_STEP,
    parameter int LINE_SIZE_MAX = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           scale_step,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic [15:0]           line_count_o
);

    import scaler_pkg::*;

    localparam int AW = (LINE_SIZE_MAX > 1) ? $clog2(LINE_SIZE_MAX) : 1;
    localparam int XW = AW + 1;
    localparam int SW = DATA_WIDTH + COE_WIDTH + 1;
    localparam int ONE = 2 ** COE_WIDTH;
    localparam int MAXV = 2 ** DATA_WIDTH - 1;
    localparam step_t UNITY = step_t'(PIXEL_STEP);
`ifdef SCALER_V_ROUND_EN
    localparam logic [SW-1:0] RND = SW'(ONE / 2);
`else
    localparam logic [SW-1:0] RND = '0;
`endif

    logic                  hs_d, hs_q;
    acc_t                  acc_d, acc_q;
    logic [INT_W-1:0]      ln_d, ln_q;
    logic [15:0]           lc_d, lc_q;
    logic                  emit_d, emit_q;
    logic                  armed_d, armed_q;
    logic [XW-1:0]         x_d, x_q;

    logic                  s1_de_d, s1_de_q;
    logic [DATA_WIDTH-1:0] s1_bot_d, s1_bot_q;
    logic [COE_WIDTH-1:0]  s1_f_d, s1_f_q;
    logic                  s1_hs_d, s1_hs_q;
    logic                  s1_vs_d, s1_vs_q;

    logic                  s2_de_d, s2_de_q;
    logic [SW-1:0]         s2_sum_d, s2_sum_q;
    logic                  s2_hs_d, s2_hs_q;
    logic                  s2_vs_d, s2_vs_q;

    logic [DATA_WIDTH-1:0] do_d, do_q;
    logic                  de_o_d, de_o_q;
    logic                  hs_o_d, hs_o_q;
    logic                  vs_o_d, vs_o_q;

    logic                  line_start, line_end;
    logic                  want_emit, emit_now;
    logic [XW-1:0]         x_cur;
    logic                  in_range;
    step_t                 step_eff;
    logic [DATA_WIDTH-1:0] top;
    logic [COE_WIDTH:0]    wt;
    logic [SW-1:0]         shifted;

    assign line_start = hs_q & ~hs_i;
    assign line_end = ~hs_q & hs_i;
    assign step_eff = clamp_step(scale_step, UNITY);
    assign want_emit = armed_q && (ln_q != '0)
        && (acc_q[ACC_W-1:FRAC_W] == ln_q - 1'b1);
    assign emit_now = line_start ? want_emit : emit_q;
    assign x_cur = line_start ? '0 : x_q;
    assign in_range = x_cur < XW'(LINE_SIZE_MAX);

    scaler_v_linebuf #(
        .DW(DATA_WIDTH),
        .DEPTH(LINE_SIZE_MAX),
        .AW(AW)
    ) u_linebuf (
        .clk(clk),
        .we(de_i & in_range),
        .waddr(x_cur[AW-1:0]),
        .wdata(di_i),
        .raddr(x_cur[AW-1:0]),
        .rdata(top)
    );

    // Line bookkeeping: position only advances after lines that were emitted.
    always_comb begin
        hs_d = hs_i;
        acc_d = acc_q;
        ln_d = ln_q;
        lc_d = lc_q;
        emit_d = emit_q;
        armed_d = armed_q;
        x_d = x_cur;
        if (line_start) emit_d = want_emit;
        if (de_i && in_range) x_d = x_cur + 1'b1;
        if (line_end) begin
            ln_d = ln_q + 1'b1;
            emit_d = 1'b0;
            if (emit_q) begin
                acc_d = acc_q + acc_t'(step_eff);
                lc_d = lc_q + 1'b1;
            end
        end
        if (vs_i) begin
            acc_d = '0;
            ln_d = '0;
            lc_d = '0;
            emit_d = 1'b0;
            armed_d = 1'b1;
        end
    end

    always_comb begin
        s1_de_d = de_i & in_range & emit_now & ~vs_i;
        s1_bot_d = di_i;
        s1_f_d = acc_q[FRAC_W-1 -: COE_WIDTH];
        s1_hs_d = hs_i;
        s1_vs_d = vs_i;

        wt = (COE_WIDTH + 1)'(ONE) - {1'b0, s1_f_q};
        s2_de_d = s1_de_q;
        s2_sum_d = SW'(top) * SW'(wt) + SW'(s1_bot_q) * SW'(s1_f_q) + RND;
        s2_hs_d = s1_hs_q;
        s2_vs_d = s1_vs_q;

        shifted = s2_sum_q >> COE_WIDTH;
        do_d = '0;
        if (s2_de_q) begin
            if (shifted > SW'(MAXV)) do_d = '1;
            else do_d = shifted[DATA_WIDTH-1:0];
        end
        de_o_d = s2_de_q;
        hs_o_d = s2_hs_q;
        vs_o_d = s2_vs_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q <= 1'b1;
            acc_q <= '0;
            ln_q <= '0;
            lc_q <= '0;
            emit_q <= 1'b0;
            armed_q <= 1'b0;
            x_q <= '0;
            s1_de_q <= 1'b0;
            s1_bot_q <= '0;
            s1_f_q <= '0;
            s1_hs_q <= 1'b1;
            s1_vs_q <= 1'b1;
            s2_de_q <= 1'b0;
            s2_sum_q <= '0;
            s2_hs_q <= 1'b1;
            s2_vs_q <= 1'b1;
            do_q <= '0;
            de_o_q <= 1'b0;
            hs_o_q <= 1'b1;
            vs_o_q <= 1'b1;
        end else begin
            hs_q <= hs_d;
            acc_q <= acc_d;
            ln_q <= ln_d;
            lc_q <= lc_d;
            emit_q <= emit_d;
            armed_q <= armed_d;
            x_q <= x_d;
            s1_de_q <= s1_de_d;
            s1_bot_q <= s1_bot_d;
            s1_f_q <= s1_f_d;
            s1_hs_q <= s1_hs_d;
            s1_vs_q <= s1_vs_d;
            s2_de_q <= s2_de_d;
            s2_sum_q <= s2_sum_d;
            s2_hs_q <= s2_hs_d;
            s2_vs_q <= s2_vs_d;
            do_q <= do_d;
            de_o_q <= de_o_d;
            hs_o_q <= hs_o_d;
            vs_o_q <= vs_o_d;
        end
    end

    assign do_o = do_q;
    assign de_o = de_o_q;
    assign hs_o = hs_o_q;
    assign vs_o = vs_o_q;
    assign line_count_o = lc_q;

endmodule

// File: tb/tb_scaler_v.sv
// Directed bench for scaler_v with a pixel scoreboard and sync-latency checks.
module tb_scaler_v;

    logic clk = 1'b0;
    logic rst;
    logic [15:0] scale_step;
    logic [15:0] lc, lc16;

    always #5 clk = ~clk;

    scaler_v_if #(.DW(8)) src ();
    scaler_v_if #(.DW(8)) dst ();
    scaler_v_if #(.DW(8)) dst16 ();

    scaler_v dut (
        .clk(clk),
        .rst(rst),
        .scale_step(scale_step),
        .di_i(src.pix),
        .de_i(src.de),
        .hs_i(src.hs),
        .vs_i(src.vs),
        .do_o(dst.pix),
        .de_o(dst.de),
        .hs_o(dst.hs),
        .vs_o(dst.vs),
        .line_count_o(lc)
    );

    scaler_v #(.LINE_SIZE_MAX(16)) dut16 (
        .clk(clk),
        .rst(rst),
        .scale_step(scale_step),
        .di_i(src.pix),
        .de_i(src.de),
        .hs_i(src.hs),
        .vs_i(src.vs),
        .do_o(dst16.pix),
        .de_o(dst16.de),
        .hs_o(dst16.hs),
        .vs_o(dst16.vs),
        .line_count_o(lc16)
    );

    int checks = 0;
    int fails = 0;
    int q[$];
    bit chk_en = 1'b0;
    int n16 = 0;
    logic [2:0] hs_h = 3'b111;
    logic [2:0] vs_h = 3'b111;

    always @(posedge clk) begin
        hs_h <= {hs_h[1:0], src.hs};
        vs_h <= {vs_h[1:0], src.vs};
    end

    // Output monitor: sync latency and scoreboard pops.
    always @(negedge clk) begin
        int e;
        if (dst16.de === 1'b1) n16++;
        if (chk_en) begin
            checks++;
            assert (dst.hs === hs_h[2]) else begin
                fails++;
                $error("FAIL hs_lat got=%b exp=%b", dst.hs, hs_h[2]);
            end
            checks++;
            assert (dst.vs === vs_h[2]) else begin
                fails++;
                $error("FAIL vs_lat got=%b exp=%b", dst.vs, vs_h[2]);
            end
        end
        if (dst.de !== 1'b0) begin
            checks++;
            assert (q.size() != 0) else begin
                fails++;
                $error("FAIL extra_de got=%0d exp=none", dst.pix);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                assert (dst.pix === 8'(e)) else begin
                    fails++;
                    $error("FAIL pixel got=%0d exp=%0d", dst.pix, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic vblank(int n);
        src.vs = 1'b1;
        src.hs = 1'b1;
        src.de = 1'b0;
        repeat (n) tick();
        src.vs = 1'b0;
        tick();
    endtask

    task automatic line(int val, int w, bit em, int ev);
        src.hs = 1'b0;
        tick();
        for (int i = 0; i < w; i++) begin
            src.de = 1'b1;
            src.pix = 8'(val);
            if (em) q.push_back(ev);
            tick();
        end
        src.de = 1'b0;
        src.hs = 1'b1;
        repeat (3) tick();
    endtask

    task automatic frame_unity();
        line(0, 4, 1'b0, 0);
        line(10, 4, 1'b1, 0);
        line(20, 4, 1'b1, 10);
        line(30, 4, 1'b1, 20);
        repeat (4) tick();
    endtask

    initial begin
        int n0;
        int rnd_exp;
`ifdef SCALER_V_ROUND_EN
        rnd_exp = 1;
`else
        rnd_exp = 0;
`endif
        src.pix = '0;
        src.de = 1'b0;
        src.hs = 1'b1;
        src.vs = 1'b1;
        scale_step = 16'd4096;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_do", int'(dst.pix), 0);
        chk("rst_de", int'(dst.de), 0);
        chk("rst_hs", int'(dst.hs), 1);
        chk("rst_vs", int'(dst.vs), 1);
        chk("rst_lc", int'(lc), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        vblank(4);
        frame_unity();
        chk("unity_lc", int'(lc), 3);
        chk("unity_lc16", int'(lc16), 3);
        vblank(4);
        chk("vs_clr_lc", int'(lc), 0);

        scale_step = 16'd6144;
        line(0, 4, 1'b0, 0);
        line(40, 4, 1'b1, 0);
        line(80, 4, 1'b1, 60);
        line(120, 4, 1'b0, 0);
        line(160, 4, 1'b1, 120);
        repeat (4) tick();
        chk("s1p5_lc", int'(lc), 3);
        vblank(4);

        scale_step = 16'd2867;
        frame_unity();
        chk("clamp_lc", int'(lc), 3);
        vblank(4);

        scale_step = 16'd6144;
        line(0, 4, 1'b0, 0);
        line(0, 4, 1'b1, 0);
        line(1, 4, 1'b1, rnd_exp);
        repeat (4) tick();
        chk("round_lc", int'(lc), 2);
        vblank(4);

        scale_step = 16'd4096;
        n0 = n16;
        line(5, 20, 1'b0, 0);
        line(15, 20, 1'b1, 5);
        line(25, 20, 1'b1, 15);
        line(35, 20, 1'b1, 25);
        repeat (4) tick();
        chk("trunc_de16", n16 - n0, 48);
        chk("trunc_lc16", int'(lc16), 3);
        chk("full_lc", int'(lc), 3);
        vblank(4);

        line(0, 4, 1'b0, 0);
        line(10, 4, 1'b1, 0);
        src.hs = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            src.de = 1'b1;
            src.pix = 8'd20;
            q.push_back(10);
            tick();
        end
        src.de = 1'b0;
        repeat (4) tick();
        chk_en = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            src.de = 1'b1;
            src.pix = 8'd20;
            tick();
        end
        src.de = 1'b0;
        src.hs = 1'b1;
        repeat (3) tick();
        chk_en = 1'b1;
        line(30, 4, 1'b0, 0);
        repeat (4) tick();
        chk("midrst_lc", int'(lc), 0);
        vblank(4);
        frame_unity();
        chk("frame1_lc", int'(lc), 3);
        vblank(4);

        chk("sb_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
